// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// The DCACHE_STATS_EN macro enables the hit/miss/writeback counters in dcache_ctrl.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    // RV32 load/store width codes (stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Tag field sized for the widest supported address.
    // Narrower tags are stored zero-extended.
    localparam int TAG_MAX = 32;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } line_t;

endpackage

// File: rtl/dcache_lane.sv
// One-word datapath: load byte extraction with sign/zero extension and
// store byte merge. Bytes of half/word accesses wrap modulo 4 within the word.
module dcache_lane
    import dcache_pkg::*;
(
    input  logic [31:0] line,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] rot;      // line rotated so the addressed byte sits in bits [7:0]
    logic [2:0]  nbytes;   // number of bytes a store writes

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [1:0] src;
            logic [1:0] k;
            assign src = offset + 2'(gi);
            assign k   = 2'(gi) - offset;
            assign rot[8*gi +: 8]    = line[{src, 3'b000} +: 8];
            assign merged[8*gi +: 8] = ({1'b0, k} < nbytes) ? wdata[{k, 3'b000} +: 8]
                                                            : line[8*gi +: 8];
        end
    endgenerate

    // Store width decode; unknown codes leave the line untouched
    always_comb begin
        nbytes = 3'd0;
        case (func3)
            F3_B:    nbytes = 3'd1;
            F3_H:    nbytes = 3'd2;
            F3_W:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    // Load extraction and extension; unknown codes return zero
    always_comb begin
        load_data = 32'd0;
        case (func3)
            F3_B:    load_data = {{24{rot[7]}}, rot[7:0]};
            F3_H:    load_data = {{16{rot[15]}}, rot[15:0]};
            F3_W:    load_data = rot;
            F3_BU:   load_data = {24'd0, rot[7:0]};
            F3_HU:   load_data = {16'd0, rot[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, direct-mapped, one-word-per-line data cache controller.
// Hits complete combinationally. A miss stalls the CPU, optionally evicts a
// dirty victim, refills from memory and then replays the held request.
// Define DCACHE_STATS_EN to add hit_count/miss_count/wb_count outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_func3,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_wb_addr,
    output logic [DATA_WIDTH-1:0] mem_wb_data,
    output logic                  mem_wb_en
`ifdef DCACHE_STATS_EN
    ,output logic [31:0]          hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 2;
    localparam int CNT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;

    line_t                 meta_reg [SETS];
    logic [DATA_WIDTH-1:0] data_ram [SETS];

    logic [INDEX_W-1:0]    index;
    logic [1:0]            offset;
    logic [TAG_W-1:0]      tag_in;
    line_t                 cur_meta;
    logic [DATA_WIDTH-1:0] cur_line;
    logic                  hit;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;
    logic                  store_hit;
    logic                  install;
    logic                  miss_detect;

    assign offset   = cpu_addr[1:0];
    assign index    = cpu_addr[INDEX_W+1:2];
    assign tag_in   = cpu_addr[ADDR_WIDTH-1:INDEX_W+2];
    assign cur_meta = meta_reg[index];
    assign cur_line = data_ram[index];
    assign hit      = cpu_req & cur_meta.valid & (cur_meta.tag == TAG_MAX'(tag_in));

    dcache_lane u_lane (
        .line      (cur_line),
        .offset    (offset),
        .func3     (cpu_func3),
        .wdata     (cpu_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    // Next-state, latency counter and all CPU/memory-facing outputs
    always_comb begin
        state_next  = state_reg;
        cnt_next    = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
        stall       = 1'b0;
        cpu_ack     = 1'b0;
        cpu_rdata   = '0;
        mem_addr    = '0;
        mem_wb_addr = '0;
        mem_wb_data = '0;
        mem_wb_en   = 1'b0;
        store_hit   = 1'b0;
        install     = 1'b0;
        miss_detect = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        cpu_ack = 1'b1;
                        if (cpu_we) store_hit = 1'b1;
                        else        cpu_rdata = load_data;
                    end else begin
                        stall       = 1'b1;
                        miss_detect = 1'b1;
                        cnt_next    = CNT_LOAD;
                        state_next  = (cur_meta.valid & cur_meta.dirty) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall       = 1'b1;
                mem_wb_addr = {cur_meta.tag[TAG_W-1:0], index, 2'b00};
                mem_wb_data = cur_line;
                // counter starts at CNT_LOAD, so this strobes on the first cycle only
                mem_wb_en   = (cnt_reg == CNT_LOAD);
                if (cnt_reg == '0) begin
                    state_next = REFILL;
                    cnt_next   = CNT_LOAD;
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_addr = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                if (cnt_reg == '0) begin
                    install    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter and line metadata; reset invalidates every line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            for (int i = 0; i < SETS; i++) begin
                meta_reg[i].valid <= 1'b0;
                meta_reg[i].dirty <= 1'b0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (install)
                meta_reg[index] <= '{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX'(tag_in)};
            else if (store_hit)
                meta_reg[index].dirty <= 1'b1;
        end
    end

    // Line data: refill capture or store merge (suppressed during reset)
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (install)
                data_ram[index] <= mem_rdata;
            else if (store_hit)
                data_ram[index] <= merged;
        end
    end

`ifdef DCACHE_STATS_EN
    // Event counters: hit acks (including replays), miss detects, writebacks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (cpu_ack)     hit_count  <= hit_count + 32'd1;
            if (miss_detect) miss_count <= miss_count + 32'd1;
            if (mem_wb_en)   wb_count   <= wb_count + 32'd1;
        end
    end
`endif

endmodule
